// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory controller for a small RISC-V style core.
//   Unified instruction/data word RAM (MEM_WORDS x 32, byte-addressed from 0)
//   plus a 4-bit LED/RGB output register at word address MMIO_ADDR.
//   One request at a time: IDLE -> WAIT -> DONE, with mem_ready pulsed in DONE.
//
// Parameters:
//   MEM_WORDS   RAM depth in 32-bit words
//   RD_LATENCY  WAIT cycles for RAM loads (1..7); stores/MMIO use one WAIT cycle
//   MMIO_ADDR   word address of the LED/RGB register
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_we/req_addr     request handshake, held until mem_ready
//   req_wdata/req_funct3          right-aligned store data, size/sign code
//   mem_ready                     one-cycle completion pulse
//   rdata                         extended load data (0 outside DONE)
//   misaligned                    trap pulse alongside mem_ready
//   led/red/green/blue            MMIO register bits [0]..[3]
//
// Build option:
//   MEM_CTRL_MISALIGN_TRAP_EN  defined: misaligned half/word accesses pulse
//   misaligned, drop the store and return 0. Undefined: addresses are aligned
//   down silently and misaligned stays 0.
//
// RAM contents are not reset; they hold whatever the array powers up with or
// whatever earlier stores wrote.

module mem_ctrl #(
  parameter int unsigned MEM_WORDS  = 2048,
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [31:0] MMIO_ADDR  = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        mem_ready,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0]  LAST  = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic [3:0]  mmio_q;

  logic [31:0] mem_q [MEM_WORDS];

  logic             accept;
  logic             finish;
  logic             size_byte, size_half;
  logic             is_mmio, in_ram, ram_load, trap;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [31:0]      ram_word, wrep, merged, lane, ext, load_val;
  logic [3:0]       wmask;

  // Access decode on the latched request. 011/110/111 fall through to word.
  assign size_byte = (f3_q[1:0] == 2'b00);
  assign size_half = (f3_q[1:0] == 2'b01);
  assign is_mmio   = (addr_q[31:2] == MMIO_ADDR[31:2]);
  assign in_ram    = ({2'b00, addr_q[31:2]} < MEM_WORDS);
  assign ram_load  = !we_q && !is_mmio;
  assign idx       = addr_q[IDX_W+1:2];
  assign ram_word  = mem_q[idx];

  // Byte offset after aligning down to the access size; identical to the raw
  // offset for aligned accesses, so it serves both build variants.
  always_comb begin
    off = addr_q[1:0];
    if (size_half) begin
      off = {addr_q[1], 1'b0};
    end else if (!size_byte) begin
      off = 2'b00;
    end
  end

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  logic unaligned;
  assign unaligned = (size_half && addr_q[0]) ||
                     (!size_byte && !size_half && (addr_q[1:0] != 2'b00));
  assign trap = unaligned;
`else
  assign trap = 1'b0;
`endif

  // Store lane merge: replicate the right-aligned data across lanes and
  // enable only the lanes the access covers.
  always_comb begin
    wrep   = wdata_q;
    wmask  = 4'b1111;
    merged = ram_word;
    if (size_byte) begin
      wrep  = {4{wdata_q[7:0]}};
      wmask = 4'b0001 << off;
    end else if (size_half) begin
      wrep  = {2{wdata_q[15:0]}};
      wmask = off[1] ? 4'b1100 : 4'b0011;
    end
    for (int unsigned b = 0; b < 4; b++) begin
      if (wmask[b]) begin
        merged[8*b +: 8] = wrep[8*b +: 8];
      end
    end
  end

  // Load extraction and extension; funct3[2] selects zero-extension.
  always_comb begin
    lane = ram_word >> {off, 3'b000};
    ext  = lane;
    if (size_byte) begin
      ext = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
    end else if (size_half) begin
      ext = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
    end
    load_val = '0;
    if (trap) begin
      load_val = '0;
    end else if (is_mmio) begin
      load_val = {28'b0, mmio_q};
    end else if (in_ram) begin
      load_val = ext;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = 3'(cnt_q + 3'd1);
        if (!ram_load || (cnt_q == LAST)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch and registered outputs. Outputs are loaded on the
  // WAIT->DONE edge, so they are non-zero only during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      f3_q    <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      mmio_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
      end
      ready_q <= finish;
      mis_q   <= finish && trap;
      rdata_q <= (finish && !we_q) ? load_val : '0;
      if (finish && we_q && is_mmio && !trap) begin
        mmio_q <= wdata_q[3:0];
      end
    end
  end

  // RAM write port, no reset. A reset during WAIT forces state_q to IDLE,
  // so finish cannot fire and the pending store is discarded.
  always_ff @(posedge clk) begin
    if (finish && we_q && !is_mmio && in_ram && !trap) begin
      mem_q[idx] <= merged;
    end
  end

  assign mem_ready  = ready_q;
  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign led        = mmio_q[0];
  assign red        = mmio_q[1];
  assign green      = mmio_q[2];
  assign blue       = mmio_q[3];

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int unsigned RDL   = 2;
  localparam int unsigned WORDS = 2048;
  localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;
  localparam int unsigned WIN   = 1024;  // bytes of RAM tracked by the model
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        mem_ready, misaligned, led, red, green, blue;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed memory window and LED register.
  logic [7:0] mb [WIN];
  logic [3:0] mmio_m = '0;

  mem_ctrl #(.MEM_WORDS(WORDS), .RD_LATENCY(RDL), .MMIO_ADDR(MMIO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_ready(mem_ready), .rdata(rdata), .misaligned(misaligned),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f3);
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 2) == (MMIO >> 2);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    int unsigned sz = acc_size(f3);
    logic [31:0] base, v;
    if (TRAP && is_mis(a, f3)) return '0;
    if (is_mmio(a)) return {28'b0, mmio_m};
    if (a >= WORDS * 4) return '0;
    base = a - (a % sz);
    v = '0;
    for (int unsigned i = 0; i < sz; i++) v = v | (32'(mb[base + i]) << (8 * i));
    if (f3 == 3'b000) return {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) return {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int unsigned sz = acc_size(f3);
    logic [31:0] base;
    if (TRAP && is_mis(a, f3)) return;
    if (is_mmio(a)) begin
      mmio_m = wd[3:0];
      return;
    end
    if (a >= WORDS * 4) return;
    base = a - (a % sz);
    for (int unsigned i = 0; i < sz; i++)
      if (base + i < WIN) mb[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  function automatic int exp_lat(input logic we, input logic [31:0] a);
    return (!we && !is_mmio(a)) ? int'(RDL) + 1 : 2;
  endfunction

  // Stimulus driver: issues one request, counts cycles from the cycle the
  // request is presented until mem_ready is seen, and flags any non-zero
  // rdata/misaligned outside the completion cycle.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input bit drop,
                        output logic [31:0] rd, output logic mis, output int lat,
                        output bit idle_bad);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    rd = '0; mis = 1'b0; lat = 99; idle_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        lat = c; rd = rdata; mis = misaligned;
        break;
      end
      if (rdata !== '0 || misaligned !== 1'b0) idle_bad = 1'b1;
      if (drop && c == 1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    if (mem_ready !== 1'b0 || rdata !== '0) idle_bad = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    checks++;
    if ({mem_ready, misaligned, rdata} !== 34'b0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", {mem_ready, misaligned, rdata});
    end
    checks++;
    if ({blue, green, red, led} !== 4'b0) begin
      errors++; $display("FAIL reset_leds got %b expected 0000", {blue, green, red, led});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_window();
    logic [31:0] rd, wd; logic mis; int lat; bit ib;
    for (int unsigned w = 0; w < WIN / 4; w++) begin
      wd = $urandom;
      access(1'b1, 32'(w * 4), wd, 3'b010, 1'b0, rd, mis, lat, ib);
      model_store(32'(w * 4), wd, 3'b010);
    end
  endtask

  task automatic test_first_load();
    logic [31:0] rd; logic mis; int lat; bit ib;
    access(1'b1, 32'h0, 32'h0000_0093, 3'b010, 1'b0, rd, mis, lat, ib);
    model_store(32'h0, 32'h0000_0093, 3'b010);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d expected 2", lat); end
    access(1'b0, 32'h0, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'h0000_0093) begin errors++; $display("FAIL first_lw got %h expected 00000093", rd); end
    checks++;
    if (ib) begin errors++; $display("FAIL first_lw_idle got 1 expected 0"); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] rd; logic mis; int lat; bit ib;
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
    logic [31:0] ads [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h102};
    logic [31:0] exs [5] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'h0000_00F1,
                             32'h0000_00F1, 32'hFFFF_8000};
    access(1'b1, 32'h100, 32'h8000_00F1, 3'b010, 1'b0, rd, mis, lat, ib);
    model_store(32'h100, 32'h8000_00F1, 3'b010);
    for (int i = 0; i < 5; i++) begin
      access(1'b0, ads[i], 32'h0, f3s[i], 1'b0, rd, mis, lat, ib);
      checks++;
      if (rd !== exs[i]) begin
        errors++; $display("FAIL sign_ext[%0d] got %h expected %h", i, rd, exs[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic mis; int lat; bit ib;
    access(1'b1, 32'h100, 32'h1122_3344, 3'b010, 1'b0, rd, mis, lat, ib);
    access(1'b1, 32'h101, 32'h0000_00AB, 3'b000, 1'b0, rd, mis, lat, ib);
    model_store(32'h100, 32'h1122_3344, 3'b010);
    model_store(32'h101, 32'h0000_00AB, 3'b000);
    access(1'b0, 32'h100, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    checks++;
    if (rd !== 32'h1122_AB44) begin errors++; $display("FAIL sb_merge got %h expected 1122ab44", rd); end
  endtask

  task automatic test_mmio();
    logic [31:0] rd; logic mis; int lat; bit ib;
    access(1'b1, MMIO, 32'h5, 3'b010, 1'b0, rd, mis, lat, ib);
    model_store(MMIO, 32'h5, 3'b010);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL mmio_latency got %0d expected 2", lat); end
    checks++;
    if ({blue, green, red, led} !== 4'b0101) begin
      errors++; $display("FAIL mmio_leds got %b expected 0101", {blue, green, red, led});
    end
    access(1'b0, MMIO, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL mmio_read got %h expected 5", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic mis; int lat; bit ib;
    logic [31:0] exp_w;
    access(1'b1, 32'h100, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    access(1'b1, 32'h102, 32'hDEAD_BEEF, 3'b010, 1'b0, rd, mis, lat, ib);
    exp_w = TRAP ? 32'h0 : 32'hDEAD_BEEF;
    model_store(32'h100, 32'h0, 3'b010);
    model_store(32'h102, 32'hDEAD_BEEF, 3'b010);
    checks++;
    if (mis !== TRAP) begin errors++; $display("FAIL misaligned_flag got %b expected %b", mis, TRAP); end
    access(1'b0, 32'h100, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    checks++;
    if (rd !== exp_w) begin errors++; $display("FAIL misaligned_store got %h expected %h", rd, exp_w); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic mis; int lat; bit ib;
    logic [31:0] old0;
    old0 = model_load(32'h0, 3'b010);
    access(1'b1, WORDS * 4, 32'hCAFE_F00D, 3'b010, 1'b0, rd, mis, lat, ib);
    access(1'b0, WORDS * 4, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL oor_load got %h expected 0", rd); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL oor_latency got %0d expected 3", lat); end
    access(1'b0, 32'h0, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    checks++;
    if (rd !== old0) begin errors++; $display("FAIL oor_alias got %h expected %h", rd, old0); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, oldv; logic mis; int lat; bit ib;
    access(1'b1, MMIO, 32'hF, 3'b010, 1'b0, rd, mis, lat, ib);
    model_store(MMIO, 32'hF, 3'b010);
    oldv = model_load(32'h200, 3'b010);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = ~oldv; req_funct3 = 3'b010;
    @(posedge clk); #3;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    checks++;
    if ({blue, green, red, led, mem_ready, misaligned} !== 6'b0 || rdata !== '0) begin
      errors++; $display("FAIL reset_mid_wait got leds=%b rdy=%b rdata=%h expected 0",
                         {blue, green, red, led}, mem_ready, rdata);
    end
    mmio_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h200, 32'h0, 3'b010, 1'b0, rd, mis, lat, ib);
    checks++;
    if (rd !== oldv) begin errors++; $display("FAIL reset_store_dropped got %h expected %h", rd, oldv); end
  endtask

  task automatic test_drop_valid();
    logic [31:0] rd; logic mis; int lat; bit ib;
    access(1'b0, 32'h104, 32'h0, 3'b010, 1'b1, rd, mis, lat, ib);
    checks++;
    if (lat !== 3 || rd !== model_load(32'h104, 3'b010)) begin
      errors++; $display("FAIL drop_valid got lat=%0d rdata=%h expected lat=3 rdata=%h",
                         lat, rd, model_load(32'h104, 3'b010));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("FAIL drop_valid_idle got 1 expected 0"); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd; logic mis; int lat; bit ib, we;
    logic [2:0] f3; int unsigned cls;
    logic [2:0] st_codes [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 9);
      if (cls < 8)       a = 32'($urandom_range(0, WIN - 1));
      else if (cls == 8) a = MMIO + 32'($urandom_range(0, 3));
      else               a = WORDS * 4 + 32'($urandom_range(0, 4095));
      we = $urandom_range(0, 1) == 1;
      f3 = we ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      wd = $urandom;
      exp_rd = we ? 32'h0 : model_load(a, f3);
      access(we, a, wd, f3, $urandom_range(0, 3) == 0, rd, mis, lat, ib);
      if (we) model_store(a, wd, f3);
      checks++;
      if (rd !== exp_rd || lat !== exp_lat(we, a) || mis !== (TRAP && is_mis(a, f3)) || ib) begin
        errors++;
        $display("FAIL random[%0d] we=%0b a=%h f3=%b got rd=%h lat=%0d mis=%b idle_bad=%b expected rd=%h lat=%0d mis=%b",
                 n, we, a, f3, rd, lat, mis, ib, exp_rd, exp_lat(we, a), TRAP && is_mis(a, f3));
      end
      checks++;
      if ({blue, green, red, led} !== mmio_m) begin
        errors++; $display("FAIL random_leds[%0d] got %b expected %b", n, {blue, green, red, led}, mmio_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    fill_window();
    test_sign_ext();
    test_byte_store();
    test_mmio();
    test_misalign();
    test_out_of_range();
    test_reset_mid_wait();
    test_drop_valid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
